// File: rtl/cfg_pkg.sv
// Shared constants and FSM state type for the serial configuration loader.
package cfg_pkg;

  localparam logic [7:0] SYNC_WORD  = 8'hA5;
  localparam int         TILE_CFG_W = 33;
  localparam int         SBOX_CFG_W = 16;
  localparam int         CHK_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    LOAD  = 2'd2,
    CHECK = 2'd3
  } cfg_state_e;

endpackage

// File: rtl/cfg_checksum.sv
// Eight-lane XOR accumulator: each payload bit folds into the lane given by its index mod 8.
module cfg_checksum
  import cfg_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic             bit_in,
  input  logic [2:0]       lane,
  output logic [CHK_W-1:0] sum
);

  logic [CHK_W-1:0] sum_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q[lane] <= sum_q[lane] ^ bit_in;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/config_loader.sv
// Serial configuration loader: sync word, payload into a shadow register, checksum,
// then an atomic commit of tile and switch-box configuration.
module config_loader
  import cfg_pkg::*;
#(
  parameter int NUM_TILES = 4,
  parameter int NUM_SBOX  = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            bit_in,
  input  logic                            bit_valid,
  output logic                            bit_ready,
  output logic [TILE_CFG_W*NUM_TILES-1:0] tile_cfg,
  output logic [SBOX_CFG_W*NUM_SBOX-1:0]  sbox_cfg,
  output logic                            busy,
  output logic                            cfg_done,
  output logic                            cfg_err,
  output cfg_state_e                      state_dbg
);

  localparam int TW    = TILE_CFG_W * NUM_TILES;
  localparam int P     = TW + SBOX_CFG_W * NUM_SBOX;
  localparam int CNT_W = $clog2(P);

  // Handshake: a bit is consumed in exactly the cycles where bit_valid && bit_ready;
  // bit_ready is a pure function of state (high in SYNC, LOAD, CHECK).
  cfg_state_e       state_q, state_d;
  logic [7:0]       window_q;
  logic [CNT_W-1:0] cnt_q;
  logic [P-1:0]     shadow_q;
  logic [P-1:0]     cfg_q;
  logic             chk_bad_q;
  logic             done_q, err_q;

  logic             take;
  logic [7:0]       window_d;
  logic             last_pay, last_chk, mism, chk_clear;
  logic [CHK_W-1:0] chk_exp;

  assign bit_ready = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign take      = bit_valid & bit_ready;
  assign window_d  = {window_q[6:0], bit_in};
  assign last_pay  = (cnt_q == CNT_W'(P - 1));
  assign last_chk  = (cnt_q[2:0] == 3'd7);
  assign mism      = bit_in ^ chk_exp[cnt_q[2:0]];
  assign chk_clear = reset | ((state_q == IDLE) & start);

  cfg_checksum u_chk (
    .clock  (clock),
    .clear  (chk_clear),
    .en     (take & (state_q == LOAD)),
    .bit_in (bit_in),
    .lane   (cnt_q[2:0]),
    .sum    (chk_exp)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SYNC;
      SYNC:    if (take && window_d == SYNC_WORD) state_d = LOAD;
      LOAD:    if (take && last_pay) state_d = CHECK;
      CHECK:   if (take && last_chk) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      window_q  <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      cfg_q     <= '0;
      chk_bad_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            window_q  <= '0;
            cnt_q     <= '0;
            chk_bad_q <= 1'b0;
          end
        end
        SYNC: begin
          if (take) window_q <= window_d;
        end
        LOAD: begin
          if (take) begin
            shadow_q[cnt_q] <= bit_in;
            cnt_q           <= last_pay ? '0 : cnt_q + CNT_W'(1);
          end
        end
        CHECK: begin
          if (take) begin
            if (last_chk) begin
              cnt_q     <= '0;
              chk_bad_q <= 1'b0;
              // Commit only when every received checksum bit matched.
              if (chk_bad_q | mism) begin
                err_q <= 1'b1;
              end else begin
                cfg_q  <= shadow_q;
                done_q <= 1'b1;
              end
            end else begin
              cnt_q     <= cnt_q + CNT_W'(1);
              chk_bad_q <= chk_bad_q | mism;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tile_cfg  = cfg_q[TW-1:0];
  assign sbox_cfg  = cfg_q[P-1:TW];
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: table of whole frames plus hand-written corner sequences.
module tb_config_loader;
  import cfg_pkg::*;

  logic         clock;
  logic         reset;
  logic         start;
  logic         bit_in;
  logic         bit_valid;
  logic         bit_ready;
  logic [131:0] tile_cfg;
  logic [63:0]  sbox_cfg;
  logic         busy;
  logic         cfg_done;
  logic         cfg_err;
  cfg_state_e   state_dbg;

  int checks = 0;
  int errors = 0;

  config_loader #(.NUM_TILES(4), .NUM_SBOX(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .tile_cfg  (tile_cfg),
    .sbox_cfg  (sbox_cfg),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .state_dbg (state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [131:0] tile;
    logic [63:0]  sbox;
    logic [7:0]   chk;
    bit           gaps;
    bit           mid_start;
    bit           good;
    logic [131:0] exp_tile;
    logic [63:0]  exp_sbox;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [195:0] act, input logic [195:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit gaps, input bit st);
    int n;
    n = gaps ? $urandom_range(2, 0) : 0;
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b0;
      bit_in    = 1'($urandom_range(1, 0));
      @(posedge clock); #1;
    end
    check("bit_ready", bit_ready, 1'b1);
    bit_in    = b;
    bit_valid = 1'b1;
    start     = st;
    @(posedge clock); #1;
    bit_valid = 1'b0;
    start     = 1'b0;
    if (st) check("state_after_mid_start", state_dbg, LOAD);
  endtask

  task automatic send_header(input bit gaps);
    logic [2:0] noise;
    logic [7:0] sw;
    noise = 3'b011;
    sw    = 8'hA5;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    for (int i = 2; i >= 0; i--) send_bit(noise[i], gaps, 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(sw[i], gaps, 1'b0);
    check("state_after_sync", state_dbg, LOAD);
  endtask

  task automatic send_frame(input logic [131:0] t, input logic [63:0] s, input logic [7:0] c,
                            input bit gaps, input bit mid_start);
    logic [195:0] pl;
    pl = {s, t};
    send_header(gaps);
    for (int k = 0; k < 196; k++) send_bit(pl[k], gaps, mid_start && (k == 50));
    check("state_after_payload", state_dbg, CHECK);
    for (int m = 0; m < 8; m++) send_bit(c[m], gaps, 1'b0);
  endtask

  task automatic check_result(input string tag, input bit good,
                              input logic [131:0] et, input logic [63:0] es);
    check({tag, "_done"}, cfg_done, good);
    check({tag, "_err"}, cfg_err, !good);
    check({tag, "_tile"}, tile_cfg, et);
    check({tag, "_sbox"}, sbox_cfg, es);
    check({tag, "_busy"}, busy, 1'b0);
    @(posedge clock); #1;
    check({tag, "_done_pulse_end"}, cfg_done, 1'b0);
    check({tag, "_err_pulse_end"}, cfg_err, 1'b0);
  endtask

  initial begin
    logic [131:0] ones_t, alt_t, alt_a5_t, b32_t;
    logic [63:0]  ones_s, alt_s, b132_s;

    ones_t   = '1;
    ones_s   = '1;
    alt_t    = {33{4'h5}};
    alt_s    = {16{4'h5}};
    alt_a5_t = {{27{4'h5}}, 4'hA, {5{4'h5}}};
    b32_t    = 132'h1_0000_0000;
    b132_s   = 64'h1;

    //          tile      sbox     chk    gaps mid  good exp_tile  exp_sbox
    vecs[0] = '{ones_t,   ones_s,  8'h0F, 0,   0,   1,   ones_t,   ones_s};
    vecs[1] = '{ones_t,   ones_s,  8'h0E, 0,   0,   0,   ones_t,   ones_s};
    vecs[2] = '{'0,       '0,      8'h00, 0,   0,   1,   '0,       '0};
    vecs[3] = '{ones_t,   ones_s,  8'h0F, 1,   0,   1,   ones_t,   ones_s};
    vecs[4] = '{alt_a5_t, alt_s,   8'hF5, 0,   1,   1,   alt_a5_t, alt_s};
    vecs[5] = '{b32_t,    '0,      8'h01, 0,   0,   1,   b32_t,    '0};
    vecs[6] = '{'0,       b132_s,  8'h10, 1,   0,   1,   '0,       b132_s};
    vecs[7] = '{alt_a5_t, alt_s,   8'hF4, 0,   0,   0,   '0,       b132_s};
    vecs[8] = '{'0,       '0,      8'h80, 1,   0,   0,   '0,       b132_s};

    reset     = 1'b1;
    start     = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_state", state_dbg, IDLE);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", bit_ready, 1'b0);
    check("rst_done", cfg_done, 1'b0);
    check("rst_err", cfg_err, 1'b0);
    check("rst_tile", tile_cfg, 132'h0);
    check("rst_sbox", sbox_cfg, 64'h0);

    for (int v = 0; v < 9; v++) begin
      send_frame(vecs[v].tile, vecs[v].sbox, vecs[v].chk, vecs[v].gaps, vecs[v].mid_start);
      check_result($sformatf("vec%0d", v), vecs[v].good, vecs[v].exp_tile, vecs[v].exp_sbox);
    end

    // bit_valid while IDLE, including the sync word, must not start anything.
    for (int i = 0; i < 12; i++) begin
      bit_in    = (i % 3 == 0);
      bit_valid = 1'b1;
      @(posedge clock); #1;
      check("idle_valid_busy", busy, 1'b0);
      check("idle_valid_ready", bit_ready, 1'b0);
    end
    bit_valid = 1'b0;
    check("idle_valid_tile", tile_cfg, 132'h0);
    check("idle_valid_sbox", sbox_cfg, b132_s);

    // Commit ones, then reset partway through the next payload.
    send_frame(ones_t, ones_s, 8'h0F, 0, 0);
    check_result("pre_abort", 1'b1, ones_t, ones_s);
    send_header(0);
    for (int k = 0; k < 100; k++) send_bit(1'b0, 0, 1'b0);
    bit_in    = 1'b0;
    bit_valid = 1'b1;
    start     = 1'b1;
    reset     = 1'b1;
    @(posedge clock); #1;
    reset     = 1'b0;
    start     = 1'b0;
    bit_valid = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_state", state_dbg, IDLE);
    check("abort_tile", tile_cfg, 132'h0);
    check("abort_sbox", sbox_cfg, 64'h0);
    check("abort_done", cfg_done, 1'b0);
    check("abort_err", cfg_err, 1'b0);
    repeat (4) begin
      @(posedge clock); #1;
      check("abort_no_done", cfg_done, 1'b0);
    end

    send_frame(alt_a5_t, alt_s, 8'hF5, 1, 1);
    check_result("post_abort", 1'b1, alt_a5_t, alt_s);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter NUM_TILES, default 4, number of logic tiles programmed.
REQ-002 SHALL have parameter NUM_SBOX, default 4, number of 4x4 switch boxes programmed.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a load frame.
REQ-006 SHALL have port bit_in  input  1  serial configuration bit.
REQ-007 SHALL have port bit_valid  input  1  bit_in is valid this cycle.
REQ-008 SHALL have port bit_ready  output  1  loader accepts bit_in this cycle.
REQ-009 SHALL have port tile_cfg  output  33*NUM_TILES  committed tile config; tile i at bits [33i+32:33i]; bit 32 of each = register-select.
REQ-010 SHALL have port sbox_cfg  output  16*NUM_SBOX  committed switch config; box j at bits [16j+15:16j].
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port cfg_done  output  1  one-cycle pulse on successful commit.
REQ-013 SHALL have port cfg_err  output  1  one-cycle pulse on checksum mismatch.

Function
REQ-014 A bit SHALL be consumed only in a cycle where bit_valid and bit_ready are both high; bit_valid with bit_ready low SHALL be ignored.
REQ-015 FSM states SHALL be IDLE, SYNC, LOAD, CHECK; bit_ready SHALL be high exactly in SYNC, LOAD, CHECK.
REQ-016 IDLE -> SYNC on start; start in any other state SHALL be ignored.
REQ-017 SYNC: consumed bits SHALL shift into an 8-bit window (newest at LSB); when window equals 8'hA5 the FSM SHALL enter LOAD next cycle with payload counter 0; no timeout.
REQ-018 LOAD: payload length P = 33*NUM_TILES + 16*NUM_SBOX (196 at defaults); payload bit k SHALL write shadow bit k, tiles first (tile 0 bit 0 first), then switch boxes in the same order.
REQ-019 Payload counter SHALL be wide enough for P and SHALL not wrap; after bit P-1 consumed, FSM SHALL enter CHECK.
REQ-020 Checksum: expected bit m (m=0..7) SHALL be XOR of all payload bits k with k mod 8 = m.
REQ-021 CHECK: 8 received bits, bit m first, SHALL be compared to expected; after the 8th bit consumed, FSM SHALL return to IDLE.
REQ-022 On match, tile_cfg/sbox_cfg SHALL load from shadow and cfg_done SHALL pulse in the cycle after the 8th checksum bit is consumed (both visible together).
REQ-023 On mismatch, cfg_err SHALL pulse in that same cycle and tile_cfg/sbox_cfg SHALL keep prior values.
REQ-024 tile_cfg/sbox_cfg SHALL never change except on a successful commit or reset; partial frames SHALL never be visible.
REQ-025 cfg_done and cfg_err SHALL never be high together.

Reset
REQ-026 On reset high at a clock edge: FSM -> IDLE, bit_ready=0, busy=0, cfg_done=0, cfg_err=0, tile_cfg=0, sbox_cfg=0, shadow, window, counters, checksum cleared.
REQ-027 Reset SHALL override start and bit_valid in the same cycle; reset mid-frame SHALL abort without commit.

Structure
REQ-028 Package cfg_pkg SHALL hold SYNC_WORD=8'hA5, TILE_CFG_W=33, SBOX_CFG_W=16, CHK_W=8, and the FSM state type.
REQ-029 Sub-module cfg_checksum SHALL implement the 8-lane XOR accumulator with clear, enable, bit and lane-index inputs.

Verification
REQ-030 Reset then start, 3 noise bits, 8'hA5, 196 bits (all 1) with correct checksum -> cfg_done pulse, tile_cfg all ones, sbox_cfg all ones.
REQ-031 Same frame, checksum bit 0 flipped -> cfg_err pulse, cfg_done stays 0, outputs unchanged from prior commit.
REQ-032 Frame with bit_valid toggling randomly 50% -> identical commit to gap-free frame; bit_valid while IDLE has no effect.
REQ-033 Reset asserted at payload bit 100 -> busy=0 next cycle, outputs 0, no cfg_done; fresh frame then commits correctly.
REQ-034 Pattern 1010... payload with 8'hA5 embedded in payload -> no resync; commit matches pattern; start during LOAD ignored.
